// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access (ME) pipeline stage with a blocking data-memory interface.
// A load or store presented by the EX/MEM register stalls the upstream
// pipeline. The request is registered onto mem_* and held stable until the
// memory answers with a one-cycle mem_ack. If no ack arrives within TIMEOUT
// busy cycles, the request is abandoned and the sticky BusError flag is set.
// After either outcome, the stage spends one DONE cycle handing the result
// to MEM/WB. Non-memory instructions pass straight through combinationally.
//
// Parameters
//   WIDTH    data / address width
//   TIMEOUT  maximum BUSY cycles to wait for mem_ack (must be >= 1)
//
// Ports
//   clk           in   clock; all state changes on the rising edge
//   reset         in   synchronous, active-high reset
//   ValidM        in   EX/MEM instruction is valid
//   MemReadM      in   instruction is a load
//   MemWriteM     in   instruction is a store (wins if both are set)
//   RegWriteInM   in   instruction writes the register file
//   ALUResultInM  in   effective address, or the ALU result for non-memory ops
//   WriteDataM    in   store data
//   mem_req       out  data-memory request (registered)
//   mem_we        out  request is a write (registered)
//   mem_addr      out  latched request address
//   mem_wdata     out  latched store data
//   mem_ack       in   one-cycle completion strobe from memory
//   mem_rdata     in   load data, valid while mem_ack is high
//   ReadDataM     out  load result to MEM/WB
//   ALUResultM    out  ALU result or address to MEM/WB
//   RegWriteM     out  register-write enable to MEM/WB
//   StallM        out  holds IF/ID/EX/ME registers (combinational)
//   BusError      out  sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidM,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             RegWriteInM,
    input  logic [WIDTH-1:0] ALUResultInM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] ReadDataM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic             RegWriteM,
    output logic             StallM,
    output logic             BusError
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter must be able to hold TIMEOUT-1, the index of the last BUSY cycle.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q,     state_d;
    logic             mem_req_q,   mem_req_d;
    logic             mem_we_q,    mem_we_d;
    logic [WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             reg_write_q, reg_write_d;
    logic [WIDTH-1:0] rdata_q,     rdata_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             bus_error_q, bus_error_d;

    logic mem_op;

    assign mem_op = ValidM & (MemReadM | MemWriteM);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_write_d = reg_write_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    state_d     = S_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWriteM;   // read+write collapses to a store
                    mem_addr_d  = ALUResultInM;
                    mem_wdata_d = WriteDataM;
                    reg_write_d = RegWriteInM;
                    cnt_d       = '0;
                end
            end

            S_BUSY: begin
                if (mem_ack) begin
                    // An ack in the final BUSY cycle still counts as success.
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_we_q ? '0 : mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the access and hand a harmless bubble to MEM/WB.
                    state_d     = S_DONE;
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    rdata_d     = '0;
                    reg_write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments so every flop samples its _d value
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every flop here is control or handshake state, so all of
            // it is reset; there is no storage array that could be left alone.
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_write_q <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_write_q <= reg_write_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline-facing outputs
    // ------------------------------------------------------------------
    // Reset gates these directly so MEM/WB sees zeros during the reset cycle
    // itself, before the state registers have had an edge to clear.
    always_comb begin
        StallM     = 1'b0;
        RegWriteM  = 1'b0;
        ReadDataM  = '0;
        ALUResultM = '0;

        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    ALUResultM = ALUResultInM;
                    if (mem_op) begin
                        StallM = 1'b1;   // bubble while the access starts
                    end else begin
                        RegWriteM = RegWriteInM & ValidM;
                    end
                end

                S_BUSY: begin
                    StallM     = 1'b1;
                    ALUResultM = mem_addr_q;
                end

                S_DONE: begin
                    ALUResultM = mem_addr_q;
                    ReadDataM  = rdata_q;
                    RegWriteM  = reg_write_q;
                end

                default: begin
                    StallM = 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign BusError  = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage. The bench acts as both the
// upstream pipeline (holding each instruction while StallM is high) and the
// data memory (acking in a chosen BUSY cycle). The expected behaviour of every
// instruction is derived from its description: a non-memory op takes a single
// pass-through cycle; a memory op acked in BUSY cycle k stalls k+1 cycles and
// then shows one DONE cycle; an unanswered op stalls TIMEOUT+1 cycles and
// ends in a DONE cycle that produces a bubble and raises BusError.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             reset;
    logic             ValidM;
    logic             MemReadM;
    logic             MemWriteM;
    logic             RegWriteInM;
    logic [WIDTH-1:0] ALUResultInM;
    logic [WIDTH-1:0] WriteDataM;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] ReadDataM;
    logic [WIDTH-1:0] ALUResultM;
    logic             RegWriteM;
    logic             StallM;
    logic             BusError;

    int errors = 0;
    int checks = 0;
    int cycle_cnt = 0;
    int last_done_cycle = 0;
    bit exp_bus_err = 1'b0;

    mem_access_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .ValidM       (ValidM),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .RegWriteInM  (RegWriteInM),
        .ALUResultInM (ALUResultInM),
        .WriteDataM   (WriteDataM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .ReadDataM    (ReadDataM),
        .ALUResultM   (ALUResultM),
        .RegWriteM    (RegWriteM),
        .StallM       (StallM),
        .BusError     (BusError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction as the upstream pipeline would, play the memory
    // side, and compare every cycle until the instruction leaves the stage.
    // ack_k: BUSY cycle (1..TIMEOUT) in which memory acks; anything else means
    // no ack. noise: additionally pulse mem_ack in IDLE and DONE, where it
    // must have no effect.
    task automatic do_instr(input string tag, input logic v, input logic rd,
                            input logic wr, input logic rw,
                            input logic [WIDTH-1:0] addr,
                            input logic [WIDTH-1:0] wdata, input int ack_k,
                            input logic [WIDTH-1:0] rdata, input bit noise);
        bit               is_mem;
        bit               timed_out;
        int               n_stall;
        logic [WIDTH-1:0] exp_rd;
        logic             exp_rw;
        is_mem       = v & (rd | wr);
        ValidM       = v;
        MemReadM     = rd;
        MemWriteM    = wr;
        RegWriteInM  = rw;
        ALUResultInM = addr;
        WriteDataM   = wdata;
        mem_ack      = 1'b0;
        if (!is_mem) begin
            @(negedge clk);
            checks++;
            if (StallM !== 1'b0) begin
                errors++; $display("FAIL %s pass stall: got %b want 0", tag, StallM);
            end
            checks++;
            if (RegWriteM !== (v & rw)) begin
                errors++; $display("FAIL %s pass regwrite: got %b want %b", tag, RegWriteM, v & rw);
            end
            checks++;
            if (ReadDataM !== '0) begin
                errors++; $display("FAIL %s pass rdata: got %h want 0", tag, ReadDataM);
            end
            if (v) begin
                checks++;
                if (ALUResultM !== addr) begin
                    errors++; $display("FAIL %s pass alu: got %h want %h", tag, ALUResultM, addr);
                end
            end
            checks++;
            if (mem_req !== 1'b0) begin
                errors++; $display("FAIL %s pass mem_req: got %b want 0", tag, mem_req);
            end
            checks++;
            if (BusError !== exp_bus_err) begin
                errors++; $display("FAIL %s pass buserr: got %b want %b", tag, BusError, exp_bus_err);
            end
            step();
        end else begin
            timed_out = !(ack_k >= 1 && ack_k <= TIMEOUT);
            n_stall   = timed_out ? TIMEOUT + 1 : ack_k + 1;
            for (int i = 0; i < n_stall; i++) begin
                mem_ack   = 1'b0;
                mem_rdata = WIDTH'($urandom);
                if (i == 0 && noise) mem_ack = 1'b1;
                if (i > 0 && i == ack_k) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clk);
                checks++;
                if (StallM !== 1'b1 || RegWriteM !== 1'b0 || ReadDataM !== '0) begin
                    errors++;
                    $display("FAIL %s stall c%0d: got stall=%b rw=%b rd=%h want 1/0/0",
                             tag, i, StallM, RegWriteM, ReadDataM);
                end
                checks++;
                if (mem_req !== (i > 0)) begin
                    errors++; $display("FAIL %s mem_req c%0d: got %b want %b", tag, i, mem_req, i > 0);
                end
                if (i > 0) begin
                    checks++;
                    if (mem_we !== wr || mem_addr !== addr || (wr && mem_wdata !== wdata)) begin
                        errors++;
                        $display("FAIL %s req c%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                                 tag, i, mem_we, mem_addr, mem_wdata, wr, addr, wdata);
                    end
                end
                step();
            end
            mem_ack   = noise;
            mem_rdata = WIDTH'($urandom);
            if (timed_out) exp_bus_err = 1'b1;
            exp_rd = (timed_out || wr) ? '0 : rdata;
            exp_rw = timed_out ? 1'b0 : rw;
            @(negedge clk);
            checks++;
            if (StallM !== 1'b0 || mem_req !== 1'b0) begin
                errors++; $display("FAIL %s done ctl: got stall=%b req=%b want 0/0", tag, StallM, mem_req);
            end
            checks++;
            if (ALUResultM !== addr) begin
                errors++; $display("FAIL %s done alu: got %h want %h", tag, ALUResultM, addr);
            end
            checks++;
            if (ReadDataM !== exp_rd) begin
                errors++; $display("FAIL %s done rdata: got %h want %h", tag, ReadDataM, exp_rd);
            end
            checks++;
            if (RegWriteM !== exp_rw) begin
                errors++; $display("FAIL %s done regwrite: got %b want %b", tag, RegWriteM, exp_rw);
            end
            checks++;
            if (BusError !== exp_bus_err) begin
                errors++; $display("FAIL %s done buserr: got %b want %b", tag, BusError, exp_bus_err);
            end
            last_done_cycle = cycle_cnt;
            step();
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        ValidM       = 1'b1;
        MemReadM     = 1'b1;
        MemWriteM    = 1'b0;
        RegWriteInM  = 1'b1;
        ALUResultInM = 16'h1234;
        WriteDataM   = 16'h5555;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || RegWriteM !== 1'b0 || ReadDataM !== '0 || ALUResultM !== '0) begin
            errors++;
            $display("FAIL reset comb: got stall=%b rw=%b rd=%h alu=%h want all 0",
                     StallM, RegWriteM, ReadDataM, ALUResultM);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || BusError !== 1'b0) begin
            errors++;
            $display("FAIL reset regs: got req=%b we=%b a=%h d=%h be=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, BusError);
        end
        step();
        reset     = 1'b0;
        ValidM    = 1'b0;
        MemReadM  = 1'b0;
        ALUResultInM = '0;
    endtask

    task automatic test_alu();
        do_instr("alu",      1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 0, '0, 1'b1);
        do_instr("alu_norw", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0000, 0, '0, 1'b0);
        do_instr("invalid",  1'b0, 1'b1, 1'b1, 1'b1, 16'h7777, 16'h1111, 0, '0, 1'b1);
    endtask

    task automatic test_load();
        do_instr("load", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 1, 16'hBEEF, 1'b0);
    endtask

    task automatic test_store();
        do_instr("store", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0008, 16'hA5A5, 3, 16'hFFFF, 1'b1);
        do_instr("rd_wr", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h3C3C, 2, 16'h7777, 1'b0);
    endtask

    task automatic test_ack_at_limit();
        do_instr("ack_last", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, TIMEOUT, 16'hCAFE, 1'b1);
    endtask

    task automatic test_timeout();
        do_instr("timeout",  1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000, 0, 16'h0000, 1'b0);
        do_instr("post_to",  1'b1, 1'b0, 1'b0, 1'b1, 16'h4321, 16'h0000, 0, '0, 1'b0);
        do_instr("post_ld",  1'b1, 1'b1, 1'b0, 1'b1, 16'h0204, 16'h0000, 2, 16'h1357, 1'b0);
    endtask

    task automatic test_reset_in_busy();
        ValidM       = 1'b1;
        MemReadM     = 1'b1;
        MemWriteM    = 1'b0;
        RegWriteInM  = 1'b1;
        ALUResultInM = 16'h0050;
        WriteDataM   = 16'h9999;
        mem_ack      = 1'b0;
        step();          // IDLE -> BUSY
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_busy busy1 req: got %b want 1", mem_req);
        end
        step();          // second BUSY cycle
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || RegWriteM !== 1'b0 || ReadDataM !== '0 || ALUResultM !== '0) begin
            errors++;
            $display("FAIL rst_busy during: got stall=%b rw=%b rd=%h alu=%h want all 0",
                     StallM, RegWriteM, ReadDataM, ALUResultM);
        end
        step();
        reset        = 1'b0;
        ValidM       = 1'b0;
        MemReadM     = 1'b0;
        RegWriteInM  = 1'b0;
        ALUResultInM = '0;
        WriteDataM   = '0;
        mem_ack      = 1'b1;
        mem_rdata    = 16'hDEAD;
        exp_bus_err  = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || BusError !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy regs: got req=%b we=%b a=%h d=%h be=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, BusError);
        end
        checks++;
        if (StallM !== 1'b0 || RegWriteM !== 1'b0 || ReadDataM !== '0 || ALUResultM !== '0) begin
            errors++;
            $display("FAIL rst_busy late_ack: got stall=%b rw=%b rd=%h alu=%h want all 0",
                     StallM, RegWriteM, ReadDataM, ALUResultM);
        end
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || RegWriteM !== 1'b0 || ReadDataM !== '0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy no_done: got stall=%b rw=%b rd=%h req=%b want all 0",
                     StallM, RegWriteM, ReadDataM, mem_req);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int d1;
        do_instr("b2b_0", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 16'h1010, 1'b0);
        d1 = last_done_cycle;
        do_instr("b2b_1", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0012, 16'h0000, 1, 16'h1212, 1'b0);
        checks++;
        if (last_done_cycle - d1 !== 3) begin
            errors++; $display("FAIL b2b spacing: got %0d want 3", last_done_cycle - d1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic v, rd, wr, rw;
            int   k;
            v  = ($urandom_range(0, 7) != 0);
            rd = 1'($urandom);
            wr = 1'($urandom);
            rw = 1'($urandom);
            k  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
            do_instr("rand", v, rd, wr, rw, WIDTH'($urandom), WIDTH'($urandom), k,
                     WIDTH'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        reset        = 1'b1;
        ValidM       = 1'b0;
        MemReadM     = 1'b0;
        MemWriteM    = 1'b0;
        RegWriteInM  = 1'b0;
        ALUResultInM = '0;
        WriteDataM   = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;

        test_reset();
        test_alu();
        test_load();
        test_store();
        test_ack_at_limit();
        test_timeout();
        test_reset_in_busy();
        test_back_to_back();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
